// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C frame timer.
//   state_t            : frame timer FSM states
//   DEF_DATA_BITS      : default data bits per byte (before the ACK slot)
//   DEF_BYTE_CNT_BITS  : default width of the per-transfer byte counter
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DATA      = 3'd1,
    WAIT_FALL = 3'd2,
    ACK_SETUP = 3'd3,
    ACK_HIGH  = 3'd4,
    ACK_END   = 3'd5,
    WAIT_STOP = 3'd6
  } state_t;

  localparam int DEF_DATA_BITS     = 8;
  localparam int DEF_BYTE_CNT_BITS = 4;

endpackage

// File: rtl/flex_counter.sv
// Simple up-counter used as the frame timer's bit counter.
//   clk          : clock, rising edge
//   n_rst        : asynchronous active-low reset
//   clear        : synchronous clear to 0 (wins over count_enable)
//   count_enable : increment by one this cycle
//   count_out    : current count
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  output logic [NUM_CNT_BITS-1:0] count_out
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out <= '0;
    end else if (clear) begin
      count_out <= '0;
    end else if (count_enable) begin
      count_out <= count_out + NUM_CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/i2c_frame_timer.sv
// I2C slave frame timer: tracks bit/ACK timing of each byte between START
// and STOP from pre-detected SCL edge and START/STOP pulses.
//   clk, n_rst                         : clock / async active-low reset
//   rising_edge_found/falling_edge_found : one-cycle SCL edge pulses
//   start_found/stop_found             : one-cycle START/STOP pulses
//   sda_sync                           : synchronised SDA, sampled at ACK rise
//   shift_strobe                       : pulse per data-bit SCL rise
//   byte_received                      : pulse per completed byte
//   ack_prep                           : level, high during ACK setup
//   check_ack / ack_done               : pulses at ACK-slot SCL rise / fall
//   nack_found                         : pulse when SDA high at ACK rise
//   frame_abort                        : pulse on START/STOP inside a byte
//   byte_count                         : bytes acked since last START (saturating)
//   bus_busy                           : level, high from START until STOP
module i2c_frame_timer
  import i2c_pkg::*;
#(
  parameter int DATA_BITS     = DEF_DATA_BITS,
  parameter int BYTE_CNT_BITS = DEF_BYTE_CNT_BITS
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     rising_edge_found,
  input  logic                     falling_edge_found,
  input  logic                     start_found,
  input  logic                     stop_found,
  input  logic                     sda_sync,
  output logic                     shift_strobe,
  output logic                     byte_received,
  output logic                     ack_prep,
  output logic                     check_ack,
  output logic                     ack_done,
  output logic                     nack_found,
  output logic                     frame_abort,
  output logic [BYTE_CNT_BITS-1:0] byte_count,
  output logic                     bus_busy
);

  localparam int               CW       = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0]    LAST_BIT = CW'(DATA_BITS - 1);

  function automatic logic [BYTE_CNT_BITS-1:0] sat_inc(input logic [BYTE_CNT_BITS-1:0] v);
    return (&v) ? v : v + BYTE_CNT_BITS'(1);
  endfunction

  state_t                   state, next_state;
  logic [CW-1:0]            bit_count;
  logic                     cnt_clear, cnt_en;
  logic                     nack_q, nack_nxt;
  logic [BYTE_CNT_BITS-1:0] byte_count_nxt;
  logic                     shift_nxt, byte_rx_nxt, ack_prep_nxt, check_nxt;
  logic                     done_nxt, nack_found_nxt, abort_nxt, busy_nxt;
  logic                     rise, fall, mid_byte;

  // A simultaneous rise and fall is treated as a rise only.
  assign rise = rising_edge_found;
  assign fall = falling_edge_found & ~rising_edge_found;

  // Inside a partially shifted byte: in DATA the counter never reaches
  // DATA_BITS, so any non-zero count means bits have been shifted.
  assign mid_byte = ((state == DATA) && (bit_count != '0)) || (state == WAIT_FALL);

  flex_counter #(.NUM_CNT_BITS(CW)) u_bit_counter (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (cnt_clear),
    .count_enable (cnt_en),
    .count_out    (bit_count)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      nack_q        <= 1'b0;
      byte_count    <= '0;
      shift_strobe  <= 1'b0;
      byte_received <= 1'b0;
      ack_prep      <= 1'b0;
      check_ack     <= 1'b0;
      ack_done      <= 1'b0;
      nack_found    <= 1'b0;
      frame_abort   <= 1'b0;
      bus_busy      <= 1'b0;
    end else begin
      state         <= next_state;
      nack_q        <= nack_nxt;
      byte_count    <= byte_count_nxt;
      shift_strobe  <= shift_nxt;
      byte_received <= byte_rx_nxt;
      ack_prep      <= ack_prep_nxt;
      check_ack     <= check_nxt;
      ack_done      <= done_nxt;
      nack_found    <= nack_found_nxt;
      frame_abort   <= abort_nxt;
      bus_busy      <= busy_nxt;
    end
  end

  // Next state: STOP beats START beats SCL edges.
  always_comb begin
    next_state = state;
    if (state == IDLE) begin
      if (start_found) next_state = DATA;
    end else if (stop_found) begin
      next_state = IDLE;
    end else if (start_found) begin
      next_state = DATA;
    end else begin
      case (state)
        DATA:      if (rise && (bit_count == LAST_BIT)) next_state = WAIT_FALL;
        WAIT_FALL: if (fall) next_state = ACK_SETUP;
        ACK_SETUP: if (rise) next_state = ACK_HIGH;
        ACK_HIGH:  if (fall) next_state = nack_q ? WAIT_STOP : ACK_END;
        ACK_END:   next_state = DATA;
        WAIT_STOP: next_state = WAIT_STOP;
        default:   next_state = IDLE;
      endcase
    end
  end

  // Output / datapath next values.
  always_comb begin
    cnt_clear      = 1'b0;
    cnt_en         = 1'b0;
    nack_nxt       = nack_q;
    byte_count_nxt = byte_count;
    shift_nxt      = 1'b0;
    byte_rx_nxt    = 1'b0;
    check_nxt      = 1'b0;
    done_nxt       = 1'b0;
    nack_found_nxt = 1'b0;
    abort_nxt      = 1'b0;
    if (state == IDLE) begin
      if (start_found) begin
        cnt_clear      = 1'b1;
        byte_count_nxt = '0;
        nack_nxt       = 1'b0;
      end
    end else if (stop_found) begin
      abort_nxt = mid_byte;
      cnt_clear = 1'b1;
      nack_nxt  = 1'b0;
    end else if (start_found) begin
      abort_nxt      = mid_byte;
      cnt_clear      = 1'b1;
      byte_count_nxt = '0;
      nack_nxt       = 1'b0;
    end else begin
      case (state)
        DATA: begin
          cnt_en    = rise;
          shift_nxt = rise;
        end
        WAIT_FALL: byte_rx_nxt = fall;
        ACK_SETUP: begin
          if (rise) begin
            check_nxt      = 1'b1;
            nack_nxt       = sda_sync;
            nack_found_nxt = sda_sync;
          end
        end
        ACK_HIGH: done_nxt = fall;
        ACK_END: begin
          byte_count_nxt = sat_inc(byte_count);
          cnt_clear      = 1'b1;
        end
        default: ;
      endcase
    end
    ack_prep_nxt = (next_state == ACK_SETUP);
    busy_nxt     = (next_state != IDLE);
  end

endmodule

// File: tb/tb_i2c_frame_timer.sv
// Directed bench for i2c_frame_timer: default 8-bit instance plus a
// DATA_BITS=4 / BYTE_CNT_BITS=2 instance sharing the same stimulus.
module tb_i2c_frame_timer;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic rise = 1'b0, fall = 1'b0, start = 1'b0, stop = 1'b0, sda = 1'b0;

  logic       shift_strobe, byte_received, ack_prep, check_ack, ack_done;
  logic       nack_found, frame_abort, bus_busy;
  logic [3:0] byte_count;

  logic       shift_strobe_4, byte_received_4, ack_prep_4, check_ack_4, ack_done_4;
  logic       nack_found_4, frame_abort_4, bus_busy_4;
  logic [1:0] byte_count_4;

  int checks = 0;
  int failures = 0;
  int n_shift = 0, n_byte = 0, n_shift4 = 0, n_byte4 = 0;

  i2c_frame_timer dut (
    .clk(clk), .n_rst(n_rst),
    .rising_edge_found(rise), .falling_edge_found(fall),
    .start_found(start), .stop_found(stop), .sda_sync(sda),
    .shift_strobe(shift_strobe), .byte_received(byte_received),
    .ack_prep(ack_prep), .check_ack(check_ack), .ack_done(ack_done),
    .nack_found(nack_found), .frame_abort(frame_abort),
    .byte_count(byte_count), .bus_busy(bus_busy)
  );

  i2c_frame_timer #(.DATA_BITS(4), .BYTE_CNT_BITS(2)) dut4 (
    .clk(clk), .n_rst(n_rst),
    .rising_edge_found(rise), .falling_edge_found(fall),
    .start_found(start), .stop_found(stop), .sda_sync(sda),
    .shift_strobe(shift_strobe_4), .byte_received(byte_received_4),
    .ack_prep(ack_prep_4), .check_ack(check_ack_4), .ack_done(ack_done_4),
    .nack_found(nack_found_4), .frame_abort(frame_abort_4),
    .byte_count(byte_count_4), .bus_busy(bus_busy_4)
  );

  always #5 clk = ~clk;

  // Pulse tallies, sampled mid-cycle.
  always @(negedge clk) begin
    if (shift_strobe)    n_shift  <= n_shift + 1;
    if (byte_received)   n_byte   <= n_byte + 1;
    if (shift_strobe_4)  n_shift4 <= n_shift4 + 1;
    if (byte_received_4) n_byte4  <= n_byte4 + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_rise();  rise = 1'b1;  step(); rise = 1'b0;  endtask
  task automatic do_fall();  fall = 1'b1;  step(); fall = 1'b0;  endtask
  task automatic do_start(); start = 1'b1; step(); start = 1'b0; endtask
  task automatic do_stop();  stop = 1'b1;  step(); stop = 1'b0;  endtask

  task automatic data_bits(input int n);
    for (int i = 0; i < n; i++) begin
      do_rise();
      do_fall();
    end
  endtask

  // ACK slot: rise, fall, then one cycle for ACK_END.
  task automatic ack_slot(input logic s);
    sda = s;
    do_rise();
    do_fall();
    sda = 1'b0;
    step();
  endtask

  int s0, b0;
  logic [1:0] exp_cnt4 [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_shift", 32'(shift_strobe), 0);
    check("rst_byte_rx", 32'(byte_received), 0);
    check("rst_ack_prep", 32'(ack_prep), 0);
    check("rst_check_ack", 32'(check_ack), 0);
    check("rst_ack_done", 32'(ack_done), 0);
    check("rst_nack", 32'(nack_found), 0);
    check("rst_abort", 32'(frame_abort), 0);
    check("rst_byte_count", 32'(byte_count), 0);
    check("rst_busy", 32'(bus_busy), 0);
    n_rst = 1'b1;
    step();

    // Single acked byte
    do_start();
    check("start_busy", 32'(bus_busy), 1);
    check("start_no_abort", 32'(frame_abort), 0);
    settle();
    s0 = n_shift; b0 = n_byte;
    data_bits(8);
    check("byte_rx_pulse", 32'(byte_received), 1);
    check("ack_prep_high", 32'(ack_prep), 1);
    sda = 1'b0;
    do_rise();
    check("check_ack_pulse", 32'(check_ack), 1);
    check("ack_no_nack", 32'(nack_found), 0);
    check("ack_prep_low", 32'(ack_prep), 0);
    do_fall();
    check("ack_done_pulse", 32'(ack_done), 1);
    step();
    check("byte_count_1", 32'(byte_count), 1);
    settle();
    check("shift_count_8", 32'(n_shift - s0), 8);
    check("byte_rx_count_1", 32'(n_byte - b0), 1);

    // Second byte then repeated START
    data_bits(8);
    ack_slot(1'b0);
    check("byte_count_2", 32'(byte_count), 2);
    do_start();
    check("rstart_no_abort", 32'(frame_abort), 0);
    check("rstart_count_clr", 32'(byte_count), 0);
    check("rstart_busy", 32'(bus_busy), 1);
    settle();
    b0 = n_byte;
    data_bits(8);
    check("rstart_byte_rx", 32'(byte_received), 1);
    ack_slot(1'b0);
    settle();
    check("rstart_byte_rx_cnt", 32'(n_byte - b0), 1);
    check("rstart_count_1", 32'(byte_count), 1);
    do_stop();
    check("stop_busy", 32'(bus_busy), 0);
    check("stop_acked_no_abort", 32'(frame_abort), 0);

    // NACK
    do_start();
    data_bits(8);
    sda = 1'b1;
    do_rise();
    check("nack_pulse", 32'(nack_found), 1);
    check("nack_check_ack", 32'(check_ack), 1);
    sda = 1'b0;
    do_fall();
    check("nack_ack_done", 32'(ack_done), 1);
    check("nack_one_cycle", 32'(nack_found), 0);
    step();
    check("nack_no_count", 32'(byte_count), 0);
    settle();
    s0 = n_shift;
    data_bits(3);
    settle();
    check("wait_stop_no_shift", 32'(n_shift - s0), 0);
    check("wait_stop_busy", 32'(bus_busy), 1);
    do_stop();
    check("nack_stop_busy", 32'(bus_busy), 0);
    check("nack_stop_no_abort", 32'(frame_abort), 0);

    // STOP inside a partial byte
    do_start();
    data_bits(3);
    do_stop();
    check("mid_stop_abort", 32'(frame_abort), 1);
    check("mid_stop_busy", 32'(bus_busy), 0);
    check("mid_stop_count", 32'(byte_count), 0);
    step();
    check("abort_one_cycle", 32'(frame_abort), 0);
    settle();
    s0 = n_shift;
    data_bits(2);
    settle();
    check("idle_no_shift", 32'(n_shift - s0), 0);

    // START while waiting for the last fall
    do_start();
    repeat (8) do_rise();
    do_start();
    check("wait_fall_abort", 32'(frame_abort), 1);
    check("wait_fall_busy", 32'(bus_busy), 1);
    data_bits(8);
    check("after_abort_byte_rx", 32'(byte_received), 1);
    ack_slot(1'b0);
    check("after_abort_count", 32'(byte_count), 1);

    // Same-cycle STOP and START: STOP wins
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check("stop_over_start", 32'(bus_busy), 0);

    // Simultaneous rise+fall counts as rise only
    do_start();
    settle();
    s0 = n_shift;
    for (int i = 0; i < 9; i++) begin
      rise = 1'b1; fall = 1'b1;
      step();
      rise = 1'b0; fall = 1'b0;
    end
    check("both_edges_no_byte_rx", 32'(byte_received), 0);
    check("both_edges_no_ack_prep", 32'(ack_prep), 0);
    settle();
    check("both_edges_shift_8", 32'(n_shift - s0), 8);
    do_fall();
    check("both_edges_then_fall", 32'(byte_received), 1);
    do_stop();
    check("ack_setup_stop_no_abort", 32'(frame_abort), 0);

    // Narrow instance: 4-bit bytes, 2-bit saturating count
    do_start();
    for (int k = 0; k < 5; k++) begin
      settle();
      s0 = n_shift4; b0 = n_byte4;
      data_bits(4);
      ack_slot(1'b0);
      settle();
      check("n4_shift", 32'(n_shift4 - s0), 4);
      check("n4_byte_rx", 32'(n_byte4 - b0), 1);
      check("n4_byte_count", 32'(byte_count_4), 32'(exp_cnt4[k]));
    end
    do_stop();

    // Asynchronous reset during ACK setup
    do_start();
    data_bits(8);
    ack_slot(1'b0);
    data_bits(8);
    check("pre_rst_ack_prep", 32'(ack_prep), 1);
    check("pre_rst_count", 32'(byte_count), 1);
    n_rst = 1'b0;
    #2;
    check("async_ack_prep", 32'(ack_prep), 0);
    check("async_byte_rx", 32'(byte_received), 0);
    check("async_busy", 32'(bus_busy), 0);
    check("async_count", 32'(byte_count), 0);
    step();
    step();
    n_rst = 1'b1;
    step();
    settle();
    s0 = n_shift; b0 = n_byte;
    data_bits(8);
    sda = 1'b1;
    do_rise();
    check("post_rst_no_check_ack", 32'(check_ack), 0);
    check("post_rst_no_nack", 32'(nack_found), 0);
    sda = 1'b0;
    do_fall();
    check("post_rst_no_ack_done", 32'(ack_done), 0);
    settle();
    check("post_rst_no_shift", 32'(n_shift - s0), 0);
    check("post_rst_no_byte_rx", 32'(n_byte - b0), 0);
    check("post_rst_idle", 32'(bus_busy), 0);
    do_start();
    check("post_rst_start_busy", 32'(bus_busy), 1);
    do_stop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
